// File: rtl/ssram_arbiter_2p_pkg.sv
// Shared types and constants for the two-port SSRAM arbiter.
package ssram_arbiter_2p_pkg;

  // Arbiter ownership state: free arbitration or locked to one port.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Burst counter width; covers MAX_BURST up to 255.
  localparam int BCNT_W = 8;

  // Lock state owned by the given port id.
  function automatic arb_state_t lock_state(input logic id);
    return (id == PORT1) ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/ssram_rr_picker.sv
// Combinational 2-way round-robin pick, honouring lock ownership.
module ssram_rr_picker
  import ssram_arbiter_2p_pkg::*;
(
  input  logic [1:0]  i_req,
  input  logic        i_last_gnt,
  input  arb_state_t  i_state,
  output logic [1:0]  o_gnt
);

  // Locked: only the owner may win. Free: single requester wins, ties go
  // to the port that did not win last.
  always_comb begin
    o_gnt = 2'b00;
    case (i_state)
      LOCK0:   o_gnt = {1'b0, i_req[0]};
      LOCK1:   o_gnt = {i_req[1], 1'b0};
      default: begin
        case (i_req)
          2'b01:   o_gnt = 2'b01;
          2'b10:   o_gnt = 2'b10;
          2'b11:   o_gnt = (i_last_gnt == PORT1) ? 2'b01 : 2'b10;
          default: o_gnt = 2'b00;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ssram_arbiter_2p.sv
// Two-port arbiter in front of a single-port synchronous SRAM.
// Same-cycle round-robin grant, optional capped lock, 1-cycle read return.
module ssram_arbiter_2p
  import ssram_arbiter_2p_pkg::*;
#(
  parameter int AW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [3:0]    m0_wb,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [3:0]    m1_wb,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_wb,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);

  arb_state_t        r_state, w_state_nxt;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
  logic              r_last_gnt, w_last_nxt;
  logic              r_rd_pend;
  logic              r_rd_id;

  logic [1:0]        w_pick;
  logic [1:0]        w_gnt;
  logic              w_gnt_any;
  logic              w_gnt_id;
  logic              w_lock_sel;
  logic              w_we_sel;
  logic [BCNT_W:0]   w_bcnt_inc;

  ssram_rr_picker u_picker (
    .i_req      ({m1_req, m0_req}),
    .i_last_gnt (r_last_gnt),
    .i_state    (r_state),
    .o_gnt      (w_pick)
  );

  // Grants are forced low during reset so the SRAM enable drops at once.
  assign w_gnt      = w_pick & {2{HRESETn}};
  assign w_gnt_any  = |w_gnt;
  assign w_gnt_id   = w_gnt[1];
  assign w_lock_sel = w_gnt_id ? m1_lock : m0_lock;
  assign w_we_sel   = w_gnt_id ? m1_we : m0_we;
  assign w_bcnt_inc = {1'b0, r_bcnt} + {{BCNT_W{1'b0}}, 1'b1};

  // State register: ownership, burst count, last winner.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ARB;
      r_bcnt     <= '0;
      r_last_gnt <= PORT1;
    end else begin
      r_state    <= w_state_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_last_gnt <= w_last_nxt;
    end
  end

  // Next-state: only a granted access moves the machine.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_last_nxt  = r_last_gnt;
    if (w_gnt_any) begin
      w_last_nxt = w_gnt_id;
      case (r_state)
        ARB: begin
          // A cap of one makes locking meaningless, so stay free.
          if (w_lock_sel && (MAX_BURST > 1)) begin
            w_state_nxt = lock_state(w_gnt_id);
            w_bcnt_nxt  = {{(BCNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          if (!w_lock_sel || (w_bcnt_inc == (BCNT_W+1)'(MAX_BURST))) begin
            w_state_nxt = ARB;
            w_bcnt_nxt  = '0;
          end else begin
            w_bcnt_nxt  = w_bcnt_inc[BCNT_W-1:0];
          end
        end
      endcase
    end
  end

  // Read tracking: remember which port owns next cycle's SRAM data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rd_pend <= 1'b0;
      r_rd_id   <= PORT0;
    end else begin
      r_rd_pend <= w_gnt_any & ~w_we_sel;
      if (w_gnt_any && !w_we_sel) r_rd_id <= w_gnt_id;
    end
  end

  // Outputs: grants, SRAM mux from the winner, steered read return.
  always_comb begin
    m0_gnt    = w_gnt[0];
    m1_gnt    = w_gnt[1];
    sram_en   = w_gnt_any;
    sram_we   = 1'b0;
    sram_wb   = 4'b0000;
    sram_addr = '0;
    sram_din  = '0;
    if (w_gnt[0]) begin
      sram_we   = m0_we;
      sram_wb   = m0_we ? m0_wb : 4'b0000;
      sram_addr = m0_addr;
      sram_din  = m0_wdata;
    end else if (w_gnt[1]) begin
      sram_we   = m1_we;
      sram_wb   = m1_we ? m1_wb : 4'b0000;
      sram_addr = m1_addr;
      sram_din  = m1_wdata;
    end
    m0_rvalid = r_rd_pend & (r_rd_id == PORT0);
    m1_rvalid = r_rd_pend & (r_rd_id == PORT1);
    m0_rdata  = m0_rvalid ? sram_dout : 32'h0;
    m1_rdata  = m1_rvalid ? sram_dout : 32'h0;
  end

endmodule

// File: tb/tb_ssram_arbiter_2p.sv
// Directed bench for ssram_arbiter_2p with a per-cycle read-return scoreboard.
module tb_ssram_arbiter_2p;

  localparam int AW = 16;
  localparam int MB = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
  logic [3:0]    m0_wb, m1_wb, sram_wb;
  logic [AW-1:0] m0_addr, m1_addr, sram_addr;
  logic [31:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata, sram_din, sram_dout;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_en, sram_we;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          vld;
    bit          port;
    logic [31:0] data;
  } ret_t;
  ret_t exp_q[$];

  ssram_arbiter_2p #(.AW(AW), .MAX_BURST(MB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_wb(m0_wb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_wb(m1_wb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_wb(sram_wb),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 HCLK = ~HCLK;

  // SRAM macro model: byte-masked write, registered read.
  logic [31:0] mem [0:255];
  logic        preload;
  always @(posedge HCLK) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[16]   <= 32'hDEADBEEF;
      sram_dout <= 32'h0;
    end else if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wb[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr[7:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input bit req, lock, we, input logic [3:0] wb,
                      input logic [AW-1:0] addr, input logic [31:0] wd);
    m0_req = req; m0_lock = lock; m0_we = we; m0_wb = wb; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic drv1(input bit req, lock, we, input logic [3:0] wb,
                      input logic [AW-1:0] addr, input logic [31:0] wd);
    m1_req = req; m1_lock = lock; m1_we = we; m1_wb = wb; m1_addr = addr; m1_wdata = wd;
  endtask

  // One cycle: check return from the previous cycle, check this cycle's
  // grant and SRAM mux, push what the next cycle should return.
  task automatic cyc(input string tag, input bit eg0, input bit eg1, input logic [31:0] erd);
    ret_t e;
    logic          ewe;
    logic [3:0]    ewb;
    logic [AW-1:0] eaddr;
    logic [31:0]   edin;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty observed=0 expected=1", tag);
      e = '{1'b0, 1'b0, 32'h0};
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'(e.vld && !e.port));
    chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'(e.vld && e.port));
    chk({tag, ".m0_rdata"}, m0_rdata, (e.vld && !e.port) ? e.data : 32'h0);
    chk({tag, ".m1_rdata"}, m1_rdata, (e.vld && e.port) ? e.data : 32'h0);
    chk({tag, ".m0_gnt"}, 32'(m0_gnt), 32'(eg0));
    chk({tag, ".m1_gnt"}, 32'(m1_gnt), 32'(eg1));
    chk({tag, ".sram_en"}, 32'(sram_en), 32'(eg0 | eg1));
    ewe = 1'b0; ewb = 4'h0; eaddr = '0; edin = 32'h0;
    if (eg0) begin
      ewe = m0_we; ewb = m0_we ? m0_wb : 4'h0; eaddr = m0_addr; edin = m0_wdata;
    end else if (eg1) begin
      ewe = m1_we; ewb = m1_we ? m1_wb : 4'h0; eaddr = m1_addr; edin = m1_wdata;
    end
    chk({tag, ".sram_we"}, 32'(sram_we), 32'(ewe));
    chk({tag, ".sram_wb"}, 32'(sram_wb), 32'(ewb));
    chk({tag, ".sram_addr"}, 32'(sram_addr), 32'(eaddr));
    chk({tag, ".sram_din"}, sram_din, edin);
    if ((eg0 && !m0_we) || (eg1 && !m1_we)) exp_q.push_back('{1'b1, eg1, erd});
    else                                    exp_q.push_back('{1'b0, 1'b0, 32'h0});
    @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0;
    preload = 1'b1;
    drv0(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    drv1(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    repeat (2) @(negedge HCLK);
    #1;
    // Outputs stay quiet in reset even with a live request.
    chk("rst.m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst.sram_en", 32'(sram_en), 32'h0);
    chk("rst.m0_rvalid", 32'(m0_rvalid), 32'h0);
    @(negedge HCLK);
    preload = 1'b0;
    HRESETn = 1'b1;
    exp_q.push_back('{1'b0, 1'b0, 32'h0});

    // Tie after reset, alternating reads; m0 wb must be masked on reads.
    drv0(1, 0, 0, 4'hF, 16'h0010, 32'h0);
    drv1(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    cyc("tie1", 1, 0, 32'hDEADBEEF);
    cyc("tie2", 0, 1, 32'hDEADBEEF);
    cyc("tie3", 1, 0, 32'hDEADBEEF);
    cyc("tie4", 0, 1, 32'hDEADBEEF);

    // Single read.
    drv1(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    drv0(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    cyc("rd", 1, 0, 32'hDEADBEEF);

    // Byte-lane write then read back.
    drv0(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    drv1(1, 0, 1, 4'b0100, 16'h0004, 32'h12AB3456);
    cyc("bwr", 0, 1, 32'h0);
    drv1(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    drv0(1, 0, 0, 4'h0, 16'h0004, 32'h0);
    cyc("brd", 1, 0, 32'h00AB0000);
    drv0(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    drv1(1, 0, 1, 4'b0001, 16'h0008, 32'h00000011);
    cyc("wr8", 0, 1, 32'h0);

    // Locked burst capped at MB accesses while m1 keeps asking.
    drv0(1, 1, 0, 4'h0, 16'h0010, 32'h0);
    drv1(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    cyc("lk1", 1, 0, 32'hDEADBEEF);
    cyc("lk2", 1, 0, 32'hDEADBEEF);
    cyc("lk3", 1, 0, 32'hDEADBEEF);
    cyc("lk4", 1, 0, 32'hDEADBEEF);
    cyc("lkcap", 0, 1, 32'hDEADBEEF);
    cyc("lk5", 1, 0, 32'hDEADBEEF);
    drv0(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    cyc("lk6", 1, 0, 32'hDEADBEEF);
    cyc("lktie", 0, 1, 32'hDEADBEEF);

    // Lock release; owner idling still blocks the other port.
    drv1(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    drv0(1, 1, 0, 4'h0, 16'h0010, 32'h0);
    cyc("rel1", 1, 0, 32'hDEADBEEF);
    drv1(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    cyc("rel2", 1, 0, 32'hDEADBEEF);
    drv0(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    cyc("blk", 0, 0, 32'h0);
    drv0(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    cyc("rel3", 1, 0, 32'hDEADBEEF);
    cyc("reltie", 0, 1, 32'hDEADBEEF);

    // Reset in the cycle after a granted, locking read.
    drv0(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    drv1(1, 1, 0, 4'h0, 16'h0010, 32'h0);
    cyc("prerst", 0, 1, 32'hDEADBEEF);
    HRESETn = 1'b0;
    #1;
    chk("mrst.m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("mrst.m1_rdata", m1_rdata, 32'h0);
    chk("mrst.m1_gnt", 32'(m1_gnt), 32'h0);
    chk("mrst.sram_en", 32'(sram_en), 32'h0);
    exp_q.delete();
    exp_q.push_back('{1'b0, 1'b0, 32'h0});
    @(negedge HCLK);
    HRESETn = 1'b1;
    drv0(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    drv1(1, 0, 0, 4'h0, 16'h0010, 32'h0);
    cyc("posttie", 1, 0, 32'hDEADBEEF);
    drv0(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    drv1(0, 0, 0, 4'h0, 16'h0000, 32'h0);
    cyc("drain", 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
